instr_sequencer: RTL and testbench

- Program feeder that sits directly upstream of the mini CPU and drives its 12-bit instruction input.
- Holds a small writable program store and a program counter.
- Issues one stored word per cycle (run mode) or one word per step pulse (step mode), and inserts NOP_WORD whenever no instruction is being issued.
- Stops at a HALT opcode or at the end of the store, then reports completion.

---
 rtl/instr_sequencer.sv | 115 +++++++++++
 tb/tb_instr_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: program feeder for the mini CPU.
// Holds a small writable program store and a program counter. Stored words are
// issued one per cycle (run mode) or one per step pulse (step mode), and
// NOP_WORD is driven in every cycle where no program word is issued.
// Execution stops at a HALT command or at the last store entry.
module instr_sequencer #(
    parameter int         DEPTH    = 16,
    parameter int         ADDR_W   = 4,
    parameter logic [3:0] HALT_OP  = 4'hF,
    parameter logic [11:0] NOP_WORD = 12'h000
) (
    input  logic              clock,
    input  logic              CLR,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [11:0]       wr_data,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic [11:0]       instr_out,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   issued_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [11:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [11:0]       mem_q [DEPTH];

    logic              issue;
    logic [11:0]       word;

    assign issue = !step_mode || step;
    assign word  = mem_q[pc_q];

    // Program store: writable only while not running; reset leaves the program intact.
    always_ff @(posedge clock) begin
        if (wr_en && (state_q != RUN)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // State register; reset aborts any run and forces a NOP onto the CPU bus.
    always_ff @(posedge clock) begin
        if (CLR) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: NOP unless a non-HALT word is issued this cycle; pc never wraps.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    if (word[11:8] == HALT_OP) begin
                        state_d = DONE;
                    end else begin
                        instr_d = word;
                        valid_d = 1'b1;
                        cnt_d   = cnt_q + (ADDR_W+1)'(1);
                        if (pc_q == ADDR_W'(DEPTH-1)) begin
                            state_d = DONE;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: scoreboard of expected issued words plus
// directed timing checks for run mode, step mode, store end, reset abort and restart.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        CLR = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [11:0] instr_out;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic [4:0]  issued_cnt;

    int checkCount = 0;
    int failCount = 0;
    logic        monitorEn = 1'b0;
    logic [11:0] modelMem [16];
    logic [11:0] expQ [$];

    instr_sequencer dut (
        .clock(clock),
        .CLR(CLR),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .step_mode(step_mode),
        .step(step),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .pc(pc),
        .busy(busy),
        .done(done),
        .issued_cnt(issued_cnt)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: every valid word is popped and compared in order; idle cycles must carry NOP.
    always @(posedge clock) begin
        #1;
        if (monitorEn) begin
            if (instr_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWord", {31'd0, instr_valid}, 32'd0);
                end else begin
                    checkOutput("sbWord", {20'd0, instr_out}, {20'd0, expQ.pop_front()});
                end
            end else begin
                checkOutput("nopWhenInvalid", {20'd0, instr_out}, 32'h000);
            end
        end
    end

    task automatic writeWord(input int addr, input logic [11:0] data);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 4'(addr);
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    // Push the words the model expects to be forwarded: stop before HALT or at store end.
    task automatic pushProgram(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (modelMem[i][11:8] == 4'hF) break;
            expQ.push_back(modelMem[i]);
            n++;
        end
    endtask

    task automatic applyStimulus(input logic doStart, input logic doStep, input logic mode);
        @(negedge clock);
        start     = doStart;
        step      = doStep;
        step_mode = mode;
    endtask

    task automatic waitDone(input string tag);
        int k;
        for (k = 0; k < 200; k++) begin
            @(posedge clock);
            #1;
            if (done) break;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        logic pulse;

        // Reset, preload store, reset again: store must survive the reset.
        repeat (2) @(posedge clock);
        @(negedge clock);
        CLR = 1'b0;
        modelMem[0] = 12'h123;
        modelMem[1] = 12'hF00;
        writeWord(0, modelMem[0]);
        writeWord(1, modelMem[1]);
        @(negedge clock);
        CLR = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rstInstr", {20'd0, instr_out}, 32'h000);
        checkOutput("rstPc", {28'd0, pc}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstValid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rstCnt", {27'd0, issued_cnt}, 32'd0);
        @(negedge clock);
        CLR = 1'b0;
        monitorEn = 1'b1;
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDone("preloadDone");
        checkOutput("preloadQ", expQ.size(), 32'd0);
        checkOutput("preloadCnt", {27'd0, issued_cnt}, 32'd1);

        // Run mode with HALT: exact latency from start.
        modelMem[0] = 12'h105; modelMem[1] = 12'h203;
        modelMem[2] = 12'h400; modelMem[3] = 12'hF00;
        for (int i = 0; i < 4; i++) writeWord(i, modelMem[i]);
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("runBusy", {31'd0, busy}, 32'd1);
        checkOutput("runFirstNop", {31'd0, instr_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checkOutput("runWord", {20'd0, instr_out}, {20'd0, modelMem[i]});
            checkOutput("runValid", {31'd0, instr_valid}, 32'd1);
            if (i < 2) @(negedge clock);
        end
        @(posedge clock);
        #1;
        checkOutput("haltInstr", {20'd0, instr_out}, 32'h000);
        checkOutput("haltDone", {31'd0, done}, 32'd1);
        checkOutput("haltCnt", {27'd0, issued_cnt}, 32'd3);
        checkOutput("haltPc", {28'd0, pc}, 32'd3);
        checkOutput("haltQ", expQ.size(), 32'd0);

        // Step mode: pulses at cycles 2, 5, 9, 12 after start.
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        seen = 0;
        for (int c = 1; c <= 14; c++) begin
            pulse = (c == 2) || (c == 5) || (c == 9) || (c == 12);
            applyStimulus(1'b0, pulse, 1'b1);
            @(posedge clock);
            #1;
            if (pulse) seen++;
            if (pulse && seen <= 3) begin
                checkOutput("stepWord", {20'd0, instr_out}, {20'd0, modelMem[seen-1]});
                checkOutput("stepValid", {31'd0, instr_valid}, 32'd1);
            end else begin
                checkOutput("stepNop", {31'd0, instr_valid}, 32'd0);
            end
            checkOutput("stepDone", {31'd0, done}, {31'd0, seen >= 4});
        end
        checkOutput("stepCnt", {27'd0, issued_cnt}, 32'd3);
        checkOutput("stepQ", expQ.size(), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // No HALT anywhere: all 16 words issued, no wrap to address 0.
        for (int i = 0; i < 16; i++) begin
            modelMem[i] = {4'h1, 4'(i), 4'(15 - i)};
            writeWord(i, modelMem[i]);
        end
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDone("fullDone");
        checkOutput("fullCnt", {27'd0, issued_cnt}, 32'd16);
        checkOutput("fullPc", {28'd0, pc}, 32'd15);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("fullQ", expQ.size(), 32'd0);
        checkOutput("fullIdleInstr", {20'd0, instr_out}, 32'h000);

        // Reset aborts a run right after the 2nd issued word.
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int k = 0; k < 50 && seen < 2; k++) begin
            @(posedge clock);
            #1;
            if (instr_valid) seen++;
        end
        checkOutput("abortSeen", seen, 32'd2);
        @(negedge clock);
        CLR = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abortInstr", {20'd0, instr_out}, 32'h000);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortPc", {28'd0, pc}, 32'd0);
        checkOutput("abortCnt", {27'd0, issued_cnt}, 32'd0);
        @(negedge clock);
        CLR = 1'b0;
        expQ.delete();

        // Write during RUN is ignored; restart from DONE replays from mem[0].
        modelMem[0] = 12'h105; modelMem[1] = 12'h203;
        modelMem[2] = 12'h400; modelMem[3] = 12'hF00;
        for (int i = 0; i < 4; i++) writeWord(i, modelMem[i]);
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 12'hABC;
        @(negedge clock);
        wr_en   = 1'b0;
        waitDone("ignWrDone");
        pushProgram(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        checkOutput("replayWord0", {20'd0, instr_out}, 32'h105);
        waitDone("replayDone");
        checkOutput("replayQ", expQ.size(), 32'd0);

        // Write and start in the same cycle: the run sees the new word.
        modelMem[0] = 12'h155;
        pushProgram(n);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 12'h155;
        start   = 1'b1;
        @(negedge clock);
        wr_en   = 1'b0;
        start   = 1'b0;
        waitDone("wrStartDone");
        checkOutput("wrStartQ", expQ.size(), 32'd0);
        checkOutput("wrStartCnt", {27'd0, issued_cnt}, 32'd3);

        monitorEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
